// File: rtl/jtframe_cen_recover_pkg.sv
// Shared definitions for the CPU clock-enable scheduler: FSM state encodings
// and the default width of the debt counter.
package jtframe_cen_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RECOVER = 2'd2
  } cen_state_e;

  localparam int unsigned RECW_DEF = 4;

endpackage

// File: rtl/jtframe_cen_recover_if.sv
// Enable/busy bundle between the enable generators, memory requesters and the CPU.
// The master side drives the enables and busy lines; the slave is the scheduler.
interface jtframe_cen_recover_if
  import jtframe_cen_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned RECW = RECW_DEF
);
  logic            cen_in;
  logic            cen_fast;
  logic [NREQ-1:0] req_busy;
  logic            recover_en;
  logic            cen_out;
  logic            stalled;
  logic [RECW-1:0] debt;
  logic            ovf;

  modport master (
    output cen_in, cen_fast, req_busy, recover_en,
    input  cen_out, stalled, debt, ovf
  );

  modport slave (
    input  cen_in, cen_fast, req_busy, recover_en,
    output cen_out, stalled, debt, ovf
  );
endinterface

// File: rtl/jtframe_cen_recover_sat_updn.sv
// Saturating up/down counter with synchronous clear and a sticky overflow flag
// that records any increment attempted while already at the maximum value.
module jtframe_sat_updn #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o,
  output logic         ovf_o
);
  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;
  logic         at_max;

  assign at_max = (cnt_q == '1);
  assign zero_o = (cnt_q == '0);
  assign cnt_o  = cnt_q;
  assign ovf_o  = ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      if (at_max) ovf_d = 1'b1;
      else        cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && !zero_o) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: rtl/jtframe_cen_recover.sv
// CPU clock-enable scheduler: gates the nominal enable while memory is busy,
// counts lost pulses as debt and repays them using the faster aligned enable.
module jtframe_cen_recover
  import jtframe_cen_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned RECW = RECW_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  jtframe_cen_recover_if.slave bus
);
  cen_state_e      state_q, state_d;
  logic [NREQ-1:0] req;
  logic            busy;
  logic            cen_in, cen_fast, recover_en;
  logic            cen_gate;
  logic            inc, dec, clr;
  logic [RECW-1:0] debt;
  logic            debt_zero;
  logic            ovf;

  assign req        = bus.req_busy;
  assign busy       = |req;
  assign cen_in     = bus.cen_in;
  assign cen_fast   = bus.cen_fast;
  assign recover_en = bus.recover_en;

  always_comb begin
    state_d  = ST_RUN;
    cen_gate = 1'b0;
    inc      = 1'b0;
    dec      = 1'b0;
    clr      = ~recover_en;
    case (state_q)
      ST_RUN: begin
        cen_gate = cen_in & ~busy;
        if (busy) begin
          state_d = ST_WAIT;
          inc     = cen_in;
        end
      end
      ST_WAIT: begin
        cen_gate = cen_in & ~busy;
        inc      = cen_in & busy;
        if (busy)                         state_d = ST_WAIT;
        else if (recover_en && !debt_zero) state_d = ST_RECOVER;
        else                               state_d = ST_RUN;
      end
      ST_RECOVER: begin
        if (busy) begin
          state_d = ST_WAIT;
          inc     = cen_in;
        end else if (!recover_en || debt_zero) begin
          // Debt already repaid: behave as RUN this cycle so no extra pulse slips out.
          state_d  = ST_RUN;
          cen_gate = cen_in;
        end else begin
          state_d  = ST_RECOVER;
          cen_gate = cen_fast;
          dec      = cen_fast & ~cen_in;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  jtframe_sat_updn #(.W(RECW)) u_debt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .inc_i  (inc),
    .dec_i  (dec),
    .cnt_o  (debt),
    .zero_o (debt_zero),
    .ovf_o  (ovf)
  );

  // Reset forces the enable low even though the RUN gating would pass cen_in.
  assign bus.cen_out = rst_n & cen_gate;
  assign bus.stalled = (state_q == ST_WAIT);
  assign bus.debt    = debt;
  assign bus.ovf     = ovf;
endmodule
